// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: 8x8 text-mode VGA, colour attributes, blinking cursor.
// Ports: CLK_50M/RST_N; wr_* map write; cursor_*; glyph ROM port; VGA out.
module vga_text_ctrl #(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter int   PIX_DIV      = 2,
  parameter int   COLOR_W      = 4,
  parameter int   COL_BITS     = 7,
  parameter int   ROW_BITS     = 6,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic                         CLK_50M,
  input  logic                         RST_N,
  input  logic                         wr_en,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  input  logic [7:0]                   wr_char,
  input  logic [7:0]                   wr_attr,
  input  logic                         cursor_en,
  input  logic [COL_BITS-1:0]          cursor_col,
  input  logic [ROW_BITS-1:0]          cursor_row,
  output logic [10:0]                  glyph_addr,
  input  logic [7:0]                   glyph_data,
  output logic [COLOR_W-1:0]           VGA_R,
  output logic [COLOR_W-1:0]           VGA_G,
  output logic [COLOR_W-1:0]           VGA_B,
  output logic                         VGA_HSYNC,
  output logic                         VGA_VSYNC,
  output logic                         de,
  output logic                         frame_start
);

  localparam int AW = ROW_BITS + COL_BITS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW0 = $clog2(H_TOTAL);
  localparam int VW0 = $clog2(V_TOTAL);
  localparam int HW = (HW0 > COL_BITS + 3) ? HW0 : COL_BITS + 3;
  localparam int VW = (VW0 > ROW_BITS + 3) ? VW0 : ROW_BITS + 3;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_L   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_L   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  function automatic logic [COLOR_W-1:0] expand(
    input logic [3:0] i, input int c);
    expand = '0;
    if (i[c]) expand = i[3] ? '1 : {1'b1, {(COLOR_W-1){1'b0}}};
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic ph_q, ph_d, run_q, run_d;
  logic de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic fs1_q, fs1_d, cur1_q, cur1_d;
  logic [2:0] vl1_q, vl1_d, hp1_q, hp1_d;
  logic de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic fs2_q, fs2_d, cur2_q, cur2_d;
  logic [2:0] hp2_q, hp2_d;
  logic [7:0] at2_q, at2_d;
  logic [10:0] ga_q, ga_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0] rd_q;
  logic [15:0] mem [0:(1<<AW)-1];

  logic pt, vis0, hs0, vs0, cur0, fs0, pix;
  logic [ROW_BITS-1:0] row0;
  logic [COL_BITS-1:0] col0;
  logic [3:0] idx;

  assign pt   = (div_q == D_LAST);
  assign row0 = vc_q[ROW_BITS+2:3];
  assign col0 = hc_q[COL_BITS+2:3];
  assign vis0 = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign hs0  = (hc_q >= HS_B && hc_q <= HS_L) ? SYNC_POL : ~SYNC_POL;
  assign vs0  = (vc_q >= VS_B && vc_q <= VS_L) ? SYNC_POL : ~SYNC_POL;
  assign cur0 = cursor_en & ph_q & (row0 == cursor_row) &
                (col0 == cursor_col) & (&vc_q[2:1]);
  // The power-up frame is never announced; only wrapped frames are.
  assign fs0  = run_q & (hc_q == '0) & (vc_q == '0);
  assign pix  = glyph_data[~hp2_q] ^ cur2_q;
  assign idx  = pix ? at2_q[3:0] : at2_q[7:4];

  // Read-first: the registered read sees the word before a same-edge write.
  always_ff @(posedge CLK_50M) begin
    if (wr_en) mem[wr_addr] <= {wr_char, wr_attr};
    if (pt) rd_q <= mem[{row0, col0}];
  end

  always_comb begin
    div_d = pt ? '0 : div_q + DW'(1);
    hc_d = hc_q; vc_d = vc_q;
    bcnt_d = bcnt_q; ph_d = ph_q; run_d = run_q;
    de1_d = de1_q; hs1_d = hs1_q; vs1_d = vs1_q;
    fs1_d = fs1_q; cur1_d = cur1_q;
    vl1_d = vl1_q; hp1_d = hp1_q;
    de2_d = de2_q; hs2_d = hs2_q; vs2_d = vs2_q;
    fs2_d = fs2_q; cur2_d = cur2_q;
    hp2_d = hp2_q; at2_d = at2_q; ga_d = ga_q;
    r_d = r_q; g_d = g_q; b_d = b_q;
    hs_d = hs_q; vs_d = vs_q; de_d = de_q;
    fs_d = 1'b0;
    if (pt) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d  = '0;
          run_d = 1'b1;
          if (bcnt_q == B_LAST) begin
            bcnt_d = '0;
            ph_d   = ~ph_q;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end else begin
          vc_d = vc_q + VW'(1);
        end
      end else begin
        hc_d = hc_q + HW'(1);
      end
      de1_d = vis0; hs1_d = hs0; vs1_d = vs0;
      fs1_d = fs0; cur1_d = cur0;
      vl1_d = vc_q[2:0]; hp1_d = hc_q[2:0];
      de2_d = de1_q; hs2_d = hs1_q; vs2_d = vs1_q;
      fs2_d = fs1_q; cur2_d = cur1_q; hp2_d = hp1_q;
      at2_d = rd_q[7:0];
      ga_d  = {rd_q[15:8], vl1_q};
      r_d = de2_q ? expand(idx, 2) : '0;
      g_d = de2_q ? expand(idx, 1) : '0;
      b_d = de2_q ? expand(idx, 0) : '0;
      hs_d = hs2_q; vs_d = vs2_q; de_d = de2_q;
      fs_d = fs2_q;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0; hc_q <= '0; vc_q <= '0;
      bcnt_q <= '0; ph_q <= 1'b0; run_q <= 1'b0;
      de1_q <= 1'b0; hs1_q <= ~SYNC_POL; vs1_q <= ~SYNC_POL;
      fs1_q <= 1'b0; cur1_q <= 1'b0; vl1_q <= '0; hp1_q <= '0;
      de2_q <= 1'b0; hs2_q <= ~SYNC_POL; vs2_q <= ~SYNC_POL;
      fs2_q <= 1'b0; cur2_q <= 1'b0; hp2_q <= '0;
      at2_q <= '0; ga_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs_q <= ~SYNC_POL; vs_q <= ~SYNC_POL;
      de_q <= 1'b0; fs_q <= 1'b0;
    end else begin
      div_q <= div_d; hc_q <= hc_d; vc_q <= vc_d;
      bcnt_q <= bcnt_d; ph_q <= ph_d; run_q <= run_d;
      de1_q <= de1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
      fs1_q <= fs1_d; cur1_q <= cur1_d; vl1_q <= vl1_d; hp1_q <= hp1_d;
      de2_q <= de2_d; hs2_q <= hs2_d; vs2_q <= vs2_d;
      fs2_q <= fs2_d; cur2_q <= cur2_d; hp2_q <= hp2_d;
      at2_q <= at2_d; ga_q <= ga_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      hs_q <= hs_d; vs_q <= vs_d;
      de_q <= de_d; fs_q <= fs_d;
    end
  end

  assign glyph_addr  = ga_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HSYNC   = hs_q;
  assign VGA_VSYNC   = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: scoreboard bench for vga_text_ctrl on a tiny raster.
// Pixels are predicted at map-read time and compared 3 pixel ticks later.
module tb_vga_text_ctrl;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 2;
  localparam int P = 2, CB = 3, RB = 2, BF = 2;
  localparam logic SP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * P;
  localparam logic [15:0] RST_V = {12'h000, ~SP, ~SP, 2'b00};

  logic CLK_50M, RST_N, wr_en, cursor_en;
  logic [RB+CB-1:0] wr_addr;
  logic [7:0] wr_char, wr_attr, glyph_data;
  logic [CB-1:0] cursor_col;
  logic [RB-1:0] cursor_row;
  logic [10:0] glyph_addr;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HSYNC, VGA_VSYNC, de, frame_start;

  vga_text_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_DIV(P), .COLOR_W(4), .COL_BITS(CB), .ROW_BITS(RB),
    .SYNC_POL(SP), .BLINK_FRAMES(BF)
  ) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .wr_attr(wr_attr),
    .cursor_en(cursor_en), .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
    .de(de), .frame_start(frame_start)
  );

  function automatic logic [7:0] glyph_f(
    input logic [7:0] c, input logic [2:0] l);
    if (c == 8'h41 && l == 3'd0) return 8'h18;
    return (c * 8'd37) ^ {l, l, l[1:0]} ^ 8'h5A;
  endfunction

  assign glyph_data = glyph_f(glyph_addr[10:3], glyph_addr[2:0]);

  function automatic logic [3:0] exp_c(input logic [3:0] i, input int c);
    if (!i[c]) return 4'h0;
    return i[3] ? 4'hF : 4'h8;
  endfunction

  initial CLK_50M = 1'b0;
  always #5 CLK_50M = ~CLK_50M;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [15:0] mirror [32];
  logic [15:0] q [$];
  logic [15:0] exp_v;
  logic run = 1'b0, cmp_pend = 1'b0, ph, first, prev_hs;
  int cyc, mh, mv, bcnt, hs_run, last_hf, last_fs;

  int row, col, ln;
  logic [15:0] e;
  logic [7:0] gl;
  logic vis, pix, cur, fsx, hsx, vsx;
  logic [3:0] idx;

  // Predict the pixel entering the pipeline on each pixel-tick edge.
  initial forever begin
    @(posedge CLK_50M);
    if (run) begin
      cyc++;
      if (cyc % P == 0) begin
        row = (mv >> 3) & ((1 << RB) - 1);
        col = (mh >> 3) & ((1 << CB) - 1);
        ln  = mv % 8;
        e   = mirror[row * (1 << CB) + col];
        gl  = glyph_f(e[15:8], 3'(ln));
        vis = (mh < HA) && (mv < VA);
        cur = cursor_en && ph && (row == int'(cursor_row)) &&
              (col == int'(cursor_col)) && (ln >= 6);
        pix = gl[7 - (mh % 8)] ^ cur;
        idx = pix ? e[3:0] : e[7:4];
        hsx = (mh >= HA + HF && mh < HA + HF + HS) ? SP : ~SP;
        vsx = (mv >= VA + VF && mv < VA + VF + VS) ? SP : ~SP;
        fsx = (mh == 0) && (mv == 0) && !first;
        if (vis)
          q.push_back({exp_c(idx, 2), exp_c(idx, 1), exp_c(idx, 0),
                       hsx, vsx, 1'b1, fsx});
        else
          q.push_back({12'h000, hsx, vsx, 1'b0, fsx});
        mh++;
        if (mh == HT) begin
          mh = 0; mv++;
          if (mv == VT) begin
            mv = 0; first = 1'b0;
            if (bcnt == BF - 1) begin bcnt = 0; ph = ~ph; end
            else bcnt++;
          end
        end
        if (q.size() == 3) exp_v = q.pop_front();
        else exp_v = RST_V;
        cmp_pend = 1'b1;
      end
    end
    if (wr_en) mirror[wr_addr] = {wr_char, wr_attr};
  end

  initial forever begin
    @(negedge CLK_50M);
    if (run) begin
      if (cmp_pend) begin
        chk("pix", {16'h0, VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC,
                    de, frame_start}, {16'h0, exp_v});
        cmp_pend = 1'b0;
      end else begin
        chk("fs_w", {31'h0, frame_start}, 32'h0);
      end
      if (VGA_HSYNC == SP) begin
        if (prev_hs != SP) begin
          if (last_hf >= 0) chk("line", 32'(cyc - last_hf), HT * P);
          last_hf = cyc;
        end
        hs_run++;
      end else if (hs_run > 0) begin
        chk("hs_w", 32'(hs_run), HS * P);
        hs_run = 0;
      end
      prev_hs = VGA_HSYNC;
      if (frame_start) begin
        if (last_fs < 0) chk("fs_first", 32'(cyc), (HT * VT + 3) * P);
        else chk("fs_per", 32'(cyc - last_fs), FRAME);
        last_fs = cyc;
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] c, input logic [7:0] t);
    @(negedge CLK_50M);
    wr_en = 1'b1; wr_addr = 5'(a); wr_char = c; wr_attr = t;
  endtask

  task automatic idle();
    @(negedge CLK_50M);
    wr_en = 1'b0;
  endtask

  task automatic start();
    mh = 0; mv = 0; cyc = 0; bcnt = 0; ph = 1'b0; first = 1'b1;
    q.delete(); cmp_pend = 1'b0;
    hs_run = 0; last_hf = -1; last_fs = -1; prev_hs = ~SP;
    RST_N = 1'b1; run = 1'b1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rgb"}, {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk({tag, "_sync"}, {30'h0, VGA_HSYNC, VGA_VSYNC}, {30'h0, ~SP, ~SP});
    chk({tag, "_de"}, {31'h0, de}, 32'h0);
    chk({tag, "_fs"}, {31'h0, frame_start}, 32'h0);
  endtask

  bit seen;

  initial begin
    RST_N = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_char = '0; wr_attr = '0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    repeat (2) @(negedge CLK_50M);
    for (int a = 0; a < 32; a++)
      wr(a, (a == 0) ? 8'h41 : 8'($urandom),
            (a == 0) ? 8'h1F : 8'($urandom));
    idle();
    chk_rst("rst");
    chk("rst_ga", {21'h0, glyph_addr}, 32'h0);
    @(negedge CLK_50M);
    start();
    cursor_en = 1'b1; cursor_row = 2'd1; cursor_col = 3'd2;

    seen = 1'b0;
    for (int i = 0; i < FRAME + 16 && !seen; i++) begin
      @(negedge CLK_50M);
      seen = frame_start;
    end
    chk("fs_to", {31'h0, seen}, 32'h1);
    chk("px0", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h008);
    repeat (3 * P) @(negedge CLK_50M);
    chk("px3", {20'h0, VGA_R, VGA_G, VGA_B}, 32'hFFF);

    for (int i = 0; i < 300; i++)
      wr(1 + int'($urandom_range(6)), 8'($urandom), 8'($urandom));
    idle();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(40)) @(negedge CLK_50M);
      wr(1 + int'($urandom_range(30)), 8'($urandom), 8'($urandom));
      idle();
    end
    repeat (4 * FRAME) @(negedge CLK_50M);

    @(posedge CLK_50M);
    #2;
    RST_N = 1'b0; run = 1'b0;
    #1;
    chk_rst("mid");
    @(negedge CLK_50M);
    start();
    repeat (FRAME + FRAME / 2) @(negedge CLK_50M);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
Parametrised 8x8-glyph text-mode VGA controller: successor to the fixed 640x480 monochrome text display. Adds generic timing and pixel-clock-enable, per-cell 4-bit foreground/background colour attributes, a blinking hardware cursor, and sync signals aligned with the pixel pipeline. Owns the character/attribute map RAM, which the CPU writes through a same-clock port. The glyph ROM is external.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
PIX_DIV, 2, CLK_50M cycles per pixel (>=1)
COLOR_W, 4, bits per colour channel (>=2)
COL_BITS, 7, cell column address bits
ROW_BITS, 6, cell row address bits
SYNC_POL, 0, sync asserted level
BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)

Ports:
CLK_50M  in  1  system clock
RST_N  in  1  asynchronous active-low reset
wr_en  in  1  map write strobe, one write per CLK_50M cycle
wr_addr  in  ROW_BITS+COL_BITS  {row,col} cell address
wr_char  in  8  character code
wr_attr  in  8  [7:4] bg index, [3:0] fg index
cursor_en  in  1  cursor enable
cursor_col  in  COL_BITS  cursor column
cursor_row  in  ROW_BITS  cursor row
glyph_addr  out  11  {char,line[2:0]} to glyph ROM
glyph_data  in  8  glyph row, MSB = leftmost pixel; valid 1 pixel tick after glyph_addr
VGA_R/VGA_G/VGA_B  out  COLOR_W each  colour
VGA_HSYNC  out  1  horizontal sync
VGA_VSYNC  out  1  vertical sync
de  out  1  display enable, aligned with RGB
frame_start  out  1  one-CLK_50M pulse when the pixel at (0,0) appears on RGB

Behaviour:
- Reset (async, RST_N=0): hcount, vcount, divider, blink counter and blink phase = 0. RGB = 0; de = 0; frame_start = 0; HSYNC/VSYNC = ~SYNC_POL. Map RAM contents are not reset.
- Pixel tick (pt): asserted one cycle in every PIX_DIV. All pipeline state advances only on pt; PIX_DIV=1 gives pt constantly high.
- hcount wraps at H_TOTAL-1 to 0, and vcount increments at that wrap. vcount wraps at V_TOTAL-1 to 0.
- Pipeline: 3 pt stages.
  - S0: map read at {vcount[ROW_BITS+2:3], hcount[COL_BITS+2:3]}.
  - S1: glyph_addr = {char, vline[2:0]} is registered.
  - S2: glyph_data sampled, pixel bit = glyph_data[7-hpix[2:0]], colour registered to output.
- Sync and de are computed from S0 counters and delayed 3 pt, so they align exactly with RGB.
- hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync uses the same rule with the V parameters.
- Map RAM: 2^(ROW_BITS+COL_BITS) x 16 bits (char, attr).
  - Writes land on the CLK_50M edge where wr_en=1, independent of pt.
  - Same-address read on a write cycle returns old data (read-first).
- Colour expansion of 4-bit index i, per channel c (R=i[2], G=i[1], B=i[0]):
  - i[c]=0 gives 0.
  - i[c]=1 with i[3]=1 gives all ones.
  - i[c]=1 with i[3]=0 gives MSB-only (1000b for COLOR_W=4).
- Output: pixel=1 selects fg, pixel=0 selects bg; RGB=0 whenever de=0.
- Cursor: pixel is inverted when all of the following hold: cursor_en=1, blink phase=1, the cell equals (cursor_row, cursor_col), and glyph line is 6 or 7. cursor_* are sampled in S0.
- Blink: the counter advances at each frame wrap; at BLINK_FRAMES-1 it resets and the phase toggles.
- Cells beyond the visible area are never read as visible; addresses outside the visible range are legal to write.
- Parameter changes need no RTL change. The block does not check that H_ACTIVE and V_ACTIVE are multiples of 8; the integrator must ensure they are.

Test Plan:
1. Defaults, reset then run 2 frames: HSYNC low for exactly 96x2=192 CLK_50M per line, line = 1600 cycles, frame = 525 lines, VSYNC low for lines 490-491, and frame_start period = 840000 cycles.
2. Write char 0x41 with attr 0x1F at addr {0,0}; glyph model row0 = 0x18: line 0 pixels 3-4 = F,F,F and others = 0,0,8 (blue half, because bg index 1 has i[3]=0); timing matches the de-aligned first pixel.
3. Set cursor_en=1 at (2,5) with BLINK_FRAMES=2: cell lines 6-7 inverted in frames 2-3, normal in frames 0-1 and 4-5.
4. Write to the same address being displayed, on the pt edge: the current pixel shows the old char and the next frame shows the new one; back-to-back writes every cycle are all retained.
5. Assert RST_N mid-line, async with no clock edge: RGB=0, syncs=1, de=0 immediately; after release hcount restarts at 0 and the first frame_start comes after a full frame.
6. Set PIX_DIV=1, H/V = 800x600 timing (40/128/88, 1/4/23), SYNC_POL=1: line = 1056 cycles, HSYNC high for 128 cycles, and RGB aligned with de.
